// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: sequencing controller between UART_rx/UART_tx and the
// command processor.
//  RX side: builds a 16-bit command from two received bytes (high, then low).
//  The command is offered with a cmd_rdy/clr_cmd_rdy handshake. A partial
//  frame is dropped if the low byte does not arrive within TIMEOUT_CYC clocks.
//  TX side: sends 8-bit responses to UART_tx. One further response can wait
//  in a 1-deep pending buffer while a byte is on the line.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  rx_rdy, rx_data       UART_rx byte available (level) and its data
//  clr_rx_rdy            combinational byte-accept strobe back to UART_rx
//  trmt, tx_data         UART_tx start pulse and byte (registered)
//  tx_done               UART_tx done level
//  cmd, cmd_rdy          assembled command and its valid level
//  clr_cmd_rdy           consumer acknowledge
//  resp, snd_resp        response byte and 1-cycle send request
//  resp_sent             pulse when a response byte completes
//  tx_busy               transmit path (or pending buffer) occupied
//  frame_err             pulse on inter-byte timeout
//  resp_ovf              pulse when a request is dropped
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        snd_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frame_err,
    output logic        resp_ovf
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_WAIT_LO = 2'd1,
        R_HOLD    = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_BUSY  = 2'd2
    } tx_state_t;

    // ------------------------------------------------------------------
    // RX command assembly
    // ------------------------------------------------------------------
    rx_state_t        rx_state;
    rx_state_t        rx_state_nxt;
    logic [7:0]       hi;
    logic [7:0]       hi_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic [15:0]      cmd_nxt;
    logic             cmd_rdy_nxt;
    logic             frame_err_nxt;
    logic             timeout;

    // Timeout only fires when no byte is present in the same cycle.
    assign timeout = (timer == TMR_LAST) && !rx_rdy;

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
        end else begin
            rx_state <= rx_state_nxt;
        end
    end

    // RX next-state
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            R_IDLE: begin
                if (rx_rdy) begin
                    rx_state_nxt = R_WAIT_LO;
                end
            end
            R_WAIT_LO: begin
                if (rx_rdy) begin
                    rx_state_nxt = R_HOLD;
                end else if (timeout) begin
                    rx_state_nxt = R_IDLE;
                end
            end
            R_HOLD: begin
                if (clr_cmd_rdy) begin
                    rx_state_nxt = R_IDLE;
                end
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // RX outputs and datapath next values
    always_comb begin
        clr_rx_rdy    = 1'b0;
        hi_nxt        = hi;
        timer_nxt     = timer;
        cmd_nxt       = cmd;
        cmd_rdy_nxt   = cmd_rdy;
        frame_err_nxt = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    hi_nxt     = rx_data;
                    timer_nxt  = '0;
                end
            end
            R_WAIT_LO: begin
                timer_nxt = timer + TMR_W'(1);
                if (rx_rdy) begin
                    clr_rx_rdy  = 1'b1;
                    cmd_nxt     = {hi, rx_data};
                    cmd_rdy_nxt = 1'b1;
                end else if (timeout) begin
                    frame_err_nxt = 1'b1;
                end
            end
            R_HOLD: begin
                // UART_rx keeps any new byte until the command is consumed.
                if (clr_cmd_rdy) begin
                    cmd_rdy_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // RX datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi        <= '0;
            timer     <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            hi        <= hi_nxt;
            timer     <= timer_nxt;
            cmd       <= cmd_nxt;
            cmd_rdy   <= cmd_rdy_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // TX response serialiser
    // ------------------------------------------------------------------
    tx_state_t  tx_state;
    tx_state_t  tx_state_nxt;
    logic [7:0] pend;
    logic [7:0] pend_nxt;
    logic       pend_vld;
    logic       pend_vld_nxt;
    logic [7:0] tx_data_nxt;
    logic       trmt_nxt;
    logic       resp_sent_nxt;
    logic       resp_ovf_nxt;
    logic       pend_drain;

    // Pending byte leaves the buffer this cycle, so a new request can refill it.
    assign pend_drain = pend_vld &&
                        ((tx_state == T_IDLE) || ((tx_state == T_BUSY) && tx_done));

    assign tx_busy = (tx_state != T_IDLE) || pend_vld;

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    // TX next-state
    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            T_IDLE: begin
                if (pend_vld || snd_resp) begin
                    tx_state_nxt = T_START;
                end
            end
            // tx_done may still show the previous frame here; UART_tx clears it on trmt.
            T_START: tx_state_nxt = T_BUSY;
            T_BUSY: begin
                if (tx_done) begin
                    tx_state_nxt = pend_vld ? T_START : T_IDLE;
                end
            end
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    // TX outputs and buffer next values
    always_comb begin
        trmt_nxt      = 1'b0;
        tx_data_nxt   = tx_data;
        resp_sent_nxt = 1'b0;
        resp_ovf_nxt  = 1'b0;
        pend_nxt      = pend;
        pend_vld_nxt  = pend_vld;

        if ((tx_state == T_BUSY) && tx_done) begin
            resp_sent_nxt = 1'b1;
        end

        // Launch a byte: the pending one first, else a fresh request in idle.
        if (pend_drain) begin
            trmt_nxt     = 1'b1;
            tx_data_nxt  = pend;
            pend_vld_nxt = 1'b0;
        end else if ((tx_state == T_IDLE) && snd_resp) begin
            trmt_nxt    = 1'b1;
            tx_data_nxt = resp;
        end

        // Requests that cannot launch directly go to the buffer or are dropped.
        if (snd_resp && ((tx_state != T_IDLE) || pend_vld)) begin
            if (!pend_vld || pend_drain) begin
                pend_nxt     = resp;
                pend_vld_nxt = 1'b1;
            end else begin
                resp_ovf_nxt = 1'b1;
            end
        end
    end

    // TX datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trmt      <= 1'b0;
            tx_data   <= '0;
            resp_sent <= 1'b0;
            resp_ovf  <= 1'b0;
            pend      <= '0;
            pend_vld  <= 1'b0;
        end else begin
            trmt      <= trmt_nxt;
            tx_data   <= tx_data_nxt;
            resp_sent <= resp_sent_nxt;
            resp_ovf  <= resp_ovf_nxt;
            pend      <= pend_nxt;
            pend_vld  <= pend_vld_nxt;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with small behavioural models of the
// UART_rx handshake and UART_tx done timing.
module tb_uart_cmd_ctrl;

    localparam int unsigned TMO    = 100;
    localparam int unsigned TX_CYC = 6;

    logic        clk;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        snd_resp;
    logic        resp_sent;
    logic        tx_busy;
    logic        frame_err;
    logic        resp_ovf;

    int errors = 0;
    int checks = 0;
    int clr_cnt = 0;
    int rs_cnt = 0;
    int ovf_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] sent_q[$];

    uart_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .snd_resp    (snd_resp),
        .resp_sent   (resp_sent),
        .tx_busy     (tx_busy),
        .frame_err   (frame_err),
        .resp_ovf    (resp_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event counters
    always @(posedge clk) if (clr_rx_rdy) clr_cnt++;
    always @(negedge clk) begin
        if (resp_sent) rs_cnt++;
        if (resp_ovf)  ovf_cnt++;
        if (frame_err) fe_cnt++;
    end

    // UART_tx model: done drops on trmt, rises TX_CYC clocks later
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (trmt) begin
                sent_q.push_back(tx_data);
                tx_done = 1'b0;
                repeat (TX_CYC) @(posedge clk);
                #1;
                tx_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rx_put(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
    endtask

    // Wait for the DUT to accept the presented byte; returns just after the accept edge.
    task automatic rx_wait(input int max_cyc, input string tag);
        int n = 0;
        #1;
        while (!clr_rx_rdy && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(clr_rx_rdy), 32'd1);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
    endtask

    task automatic clear_cmd();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_req(input logic [7:0] b);
        @(negedge clk);
        resp     = b;
        snd_resp = 1'b1;
    endtask

    task automatic wait_tx_idle(input string tag);
        int n = 0;
        while (tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(tx_busy), 32'd0);
    endtask

    initial begin
        int c0;
        int r0;
        int o0;
        int f0;
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
        resp = '0; snd_resp = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({trmt, cmd_rdy, tx_busy, clr_rx_rdy, frame_err, resp_sent, resp_ovf}), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: two-byte frame
        rx_put(8'hA5); rx_wait(20, "t1_acc_hi");
        chk("t1_no_rdy_after_hi", 32'(cmd_rdy), 32'd0);
        rx_put(8'h3C); rx_wait(20, "t1_acc_lo");
        chk("t1_cmd", 32'(cmd), 32'hA53C);
        chk("t1_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("t1_clr_cnt", 32'(clr_cnt), 32'd2);

        // 2: third byte waits while command is unacknowledged
        rx_put(8'h11);
        repeat (5) @(negedge clk);
        chk("t2_cmd_held", 32'(cmd), 32'hA53C);
        chk("t2_rdy_held", 32'(cmd_rdy), 32'd1);
        chk("t2_not_taken", 32'(clr_cnt), 32'd2);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("t2_rdy_cleared", 32'(cmd_rdy), 32'd0);
        chk("t2_still_not_taken", 32'(clr_cnt), 32'd2);
        rx_wait(5, "t2_acc_after_clr");
        chk("t2_clr_cnt", 32'(clr_cnt), 32'd3);
        rx_put(8'h22); rx_wait(20, "t2_acc_lo");
        chk("t2_cmd", 32'(cmd), 32'h1122);
        clear_cmd();

        // 3: inter-byte timeout, then a clean frame
        f0 = fe_cnt;
        rx_put(8'h12); rx_wait(20, "t3_acc_hi");
        for (int k = 1; k <= 101; k++) begin
            @(posedge clk);
            #1;
            if (k == 99)  chk("t3_fe_early", 32'(frame_err), 32'd0);
            if (k == 100) chk("t3_fe_at_100", 32'(frame_err), 32'd1);
            if (k == 101) chk("t3_fe_pulse", 32'(frame_err), 32'd0);
        end
        chk("t3_fe_cnt", 32'(fe_cnt - f0), 32'd1);
        chk("t3_no_cmd", 32'({cmd_rdy, cmd}), 32'({1'b0, 16'h1122}));
        rx_put(8'h34); rx_wait(20, "t3_acc_hi2");
        rx_put(8'h56); rx_wait(20, "t3_acc_lo2");
        chk("t3_cmd", 32'(cmd), 32'h3456);
        clear_cmd();

        // 3b: low byte on the final timeout cycle wins
        f0 = fe_cnt;
        rx_put(8'h77); rx_wait(20, "t3b_acc_hi");
        repeat (99) @(posedge clk);
        rx_put(8'h88); rx_wait(1, "t3b_acc_lo");
        chk("t3b_no_fe", 32'(fe_cnt - f0), 32'd0);
        chk("t3b_cmd", 32'({cmd_rdy, cmd}), 32'({1'b1, 16'h7788}));
        clear_cmd();

        // 4: two responses back to back
        sent_q.delete();
        r0 = rs_cnt; o0 = ovf_cnt;
        send_req(8'hA5);
        @(negedge clk); snd_resp = 1'b0;
        chk("t4_busy", 32'(tx_busy), 32'd1);
        send_req(8'h5A);
        @(negedge clk); snd_resp = 1'b0;
        wait_tx_idle("t4_idle");
        chk("t4_sent_at_fall", 32'(resp_sent), 32'd1);
        @(posedge clk); #1;
        chk("t4_rs_cnt", 32'(rs_cnt - r0), 32'd2);
        chk("t4_ovf", 32'(ovf_cnt - o0), 32'd0);
        chk("t4_n", 32'(sent_q.size()), 32'd2);
        if (sent_q.size() == 2) begin
            chk("t4_b0", 32'(sent_q[0]), 32'hA5);
            chk("t4_b1", 32'(sent_q[1]), 32'h5A);
        end

        // 5: overflow on third request
        sent_q.delete();
        r0 = rs_cnt; o0 = ovf_cnt;
        send_req(8'h01);
        send_req(8'h02);
        send_req(8'h03);
        @(negedge clk); snd_resp = 1'b0;
        wait_tx_idle("t5_idle");
        @(posedge clk); #1;
        chk("t5_ovf", 32'(ovf_cnt - o0), 32'd1);
        chk("t5_rs_cnt", 32'(rs_cnt - r0), 32'd2);
        chk("t5_n", 32'(sent_q.size()), 32'd2);
        if (sent_q.size() == 2) begin
            chk("t5_b0", 32'(sent_q[0]), 32'h01);
            chk("t5_b1", 32'(sent_q[1]), 32'h02);
        end

        // 6: reset mid-frame and mid-transmit
        rx_put(8'hAB); rx_wait(20, "t6_acc_hi");
        send_req(8'h77);
        @(negedge clk);
        snd_resp = 1'b0;
        rx_data  = 8'hCD;
        rx_rdy   = 1'b1;
        chk("t6_trmt_pre", 32'(trmt), 32'd1);
        #2;
        rst_n  = 1'b0;
        rx_rdy = 1'b0;
        #1;
        chk("t6_rst_outs", 32'({trmt, cmd_rdy, tx_busy, clr_rx_rdy, frame_err, resp_sent, resp_ovf}), 32'd0);
        chk("t6_rst_data", 32'({cmd, tx_data}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        rx_put(8'h9A); rx_wait(20, "t6_acc_hi2");
        rx_put(8'hBC); rx_wait(20, "t6_acc_lo2");
        chk("t6_cmd", 32'({cmd_rdy, cmd}), 32'({1'b1, 16'h9ABC}));
        chk("t6_tx_idle", 32'(tx_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
